// File: rtl/seq_detector_param_if.sv
// Serial detector bus: data bit, valid, mode, pattern load, and results.
// master drives the stream and load; slave returns out/match_count/pattern_q.
interface seq_detector_param_if #(
  parameter int N     = 6,
  parameter int CNT_W = 8
) ();
  logic             in;
  logic             in_valid;
  logic             overlap;
  logic             load;
  logic [N-1:0]     load_pattern;
  logic             out;
  logic [CNT_W-1:0] match_count;
  logic [N-1:0]     pattern_q;

  modport master (
    output in, in_valid, overlap,
    output load, load_pattern,
    input  out, match_count, pattern_q
  );

  modport slave (
    input  in, in_valid, overlap,
    input  load, load_pattern,
    output out, match_count, pattern_q
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with reload, overlap mode, counter.
// Ports: clk, r (sync active-high reset), bus (slave side of detector bus).
module seq_detector_param #(
  parameter int             N       = 6,
  parameter logic [N-1:0]   PATTERN = 6'b101011,
  parameter int             CNT_W   = 8
) (
  input logic                  clk,
  input logic                  r,
  seq_detector_param_if.slave  bus
);
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);

  logic [N-1:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     pat_q, pat_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     hist_n;
  logic [FW-1:0]    fill_n;
  logic             match;

  always_comb begin
    hist_n = {hist_q[N-2:0], bus.in};
    fill_n = (fill_q == FULL) ? FULL
                              : fill_q + 1'b1;
    match  = (fill_n == FULL) &&
             (hist_n == pat_q);
  end

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;
    out_d  = 1'b0;
    // load outranks a valid bit; that bit is dropped
    if (bus.load) begin
      pat_d  = bus.load_pattern;
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (bus.in_valid) begin
      hist_d = hist_n;
      out_d  = match;
      fill_d = fill_n;
      if (match) begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
        // non-overlap: next match needs N fresh bits
        if (!bus.overlap) begin
          fill_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      out_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.out         = out_q;
  assign bus.match_count = cnt_q;
  assign bus.pattern_q   = pat_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: bit-queue reference model plus directed cases.
// Two DUTs: default config, and CNT_W=2 / all-ones pattern for saturation.
module tb_seq_detector_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra, rb;
  seq_detector_param_if #(.N(6), .CNT_W(8)) ia ();
  seq_detector_param_if #(.N(6), .CNT_W(2)) ib ();

  seq_detector_param #(
    .N(6), .PATTERN(6'b101011), .CNT_W(8)
  ) dut_a (
    .clk(clk), .r(ra), .bus(ia.slave)
  );

  seq_detector_param #(
    .N(6), .PATTERN(6'b111111), .CNT_W(2)
  ) dut_b (
    .clk(clk), .r(rb), .bus(ib.slave)
  );

  int tests = 0;
  int fails = 0;
  int pa = 0;
  int pb = 0;
  bit started = 1'b0;

  logic [5:0] m_pat [2];
  logic [5:0] m_rst [2];
  int         m_cnt [2];
  int         m_max [2];
  bit         m_out [2];
  bit qa[$];
  bit qb[$];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  function automatic bit tail_eq(bit q[$],
                                 logic [5:0] p);
    int base;
    base = q.size() - 6;
    for (int i = 0; i < 6; i++)
      if (q[base + i] != p[5 - i]) return 1'b0;
    return 1'b1;
  endfunction

  // Model: queue holds the fresh bits since the last
  // clear; a match is the last six of them equal to
  // the pattern, MSB first.
  task automatic step(int id, bit rr, bit ld,
                      logic [5:0] lp, bit v,
                      bit b, bit ov);
    bit q[$];
    if (id == 0) q = qa;
    else q = qb;
    m_out[id] = 1'b0;
    if (rr) begin
      m_pat[id] = m_rst[id];
      q.delete();
      m_cnt[id] = 0;
    end else if (ld) begin
      m_pat[id] = lp;
      q.delete();
      m_cnt[id] = 0;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > 6) void'(q.pop_front());
      if (q.size() == 6 && tail_eq(q, m_pat[id])) begin
        m_out[id] = 1'b1;
        if (m_cnt[id] < m_max[id]) m_cnt[id]++;
        if (!ov) q.delete();
      end
    end
    if (id == 0) qa = q;
    else qb = q;
  endtask

  always @(posedge clk) begin
    step(0, ra, ia.load, ia.load_pattern,
         ia.in_valid, ia.in, ia.overlap);
    step(1, rb, ib.load, ib.load_pattern,
         ib.in_valid, ib.in, ib.overlap);
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_out", 32'(ia.out), 32'(m_out[0]));
      chk("a_cnt", 32'(ia.match_count), m_cnt[0]);
      chk("a_pat", 32'(ia.pattern_q), 32'(m_pat[0]));
      chk("b_out", 32'(ib.out), 32'(m_out[1]));
      chk("b_cnt", 32'(ib.match_count), m_cnt[1]);
      chk("b_pat", 32'(ib.pattern_q), 32'(m_pat[1]));
      if (ia.out === 1'b1) pa++;
      if (ib.out === 1'b1) pb++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ra = 0; ia.load = 0; ia.in_valid = 0;
    rb = 0; ib.load = 0; ib.in_valid = 0;
  endtask

  task automatic a_bit(bit b, bit ov);
    idle();
    ia.in_valid = 1; ia.in = b; ia.overlap = ov;
    tick();
  endtask

  task automatic a_rst();
    idle();
    ra = 1;
    tick();
  endtask

  task automatic a_seq(logic [10:0] s, bit ov);
    for (int i = 10; i >= 0; i--) a_bit(s[i], ov);
  endtask

  initial begin
    m_rst[0] = 6'b101011; m_max[0] = 255;
    m_rst[1] = 6'b111111; m_max[1] = 3;
    m_pat[0] = 'x; m_pat[1] = 'x;
    m_cnt[0] = 0; m_cnt[1] = 0;
    idle();
    ia.in = 0; ia.overlap = 1; ia.load_pattern = 0;
    ib.in = 0; ib.overlap = 1; ib.load_pattern = 0;
    ra = 1; rb = 1;
    tick();
    started = 1'b1;
    chk("rst_out", 32'(ia.out), 0);
    chk("rst_cnt", 32'(ia.match_count), 0);
    chk("rst_pat", 32'(ia.pattern_q), 32'h2b);

    pa = 0;
    a_seq(11'b10101101011, 1'b1);
    idle(); tick();
    chk("ov1_pulses", pa, 2);
    chk("ov1_cnt", 32'(ia.match_count), 2);

    a_rst();
    pa = 0;
    a_seq(11'b10101101011, 1'b0);
    idle(); tick();
    chk("ov0_pulses", pa, 1);
    chk("ov0_cnt", 32'(ia.match_count), 1);

    a_rst();
    pa = 0;
    a_bit(1, 1); a_bit(0, 1); a_bit(1, 1);
    idle(); tick(); tick(); tick();
    a_bit(0, 1); a_bit(1, 1); a_bit(1, 1);
    idle(); tick();
    chk("gap_pulses", pa, 1);
    chk("gap_cnt", 32'(ia.match_count), 1);

    idle();
    ia.load = 1; ia.load_pattern = 6'b111000;
    ia.in_valid = 1; ia.in = 1;
    tick();
    chk("ld_pat", 32'(ia.pattern_q), 32'h38);
    chk("ld_cnt", 32'(ia.match_count), 0);
    pa = 0;
    a_bit(1, 1); a_bit(1, 1); a_bit(1, 1);
    a_bit(0, 1); a_bit(0, 1);
    chk("ld_early", pa, 0);
    a_bit(0, 1);
    idle(); tick();
    chk("ld_pulses", pa, 1);
    chk("ld_cnt2", 32'(ia.match_count), 1);

    idle(); rb = 1; tick();
    pb = 0;
    for (int i = 0; i < 12; i++) begin
      idle();
      ib.in_valid = 1; ib.in = 1; ib.overlap = 1;
      tick();
    end
    idle(); tick();
    chk("sat_pulses", pb, 7);
    chk("sat_cnt", 32'(ib.match_count), 3);

    a_rst();
    a_bit(1, 1); a_bit(0, 1); a_bit(1, 1);
    a_bit(0, 1); a_bit(1, 1);
    idle();
    ra = 1; ia.in_valid = 1; ia.in = 1;
    tick();
    chk("rf_out", 32'(ia.out), 0);
    chk("rf_cnt", 32'(ia.match_count), 0);
    chk("rf_pat", 32'(ia.pattern_q), 32'h2b);
    pa = 0;
    a_bit(1, 1);
    idle(); tick();
    chk("rf_pulses", pa, 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector for single-bit input streams. It is the successor to the fixed-pattern cycle detector: pattern length and reset pattern are parameters, and the pattern can be reloaded at run time. It adds an overlap/non-overlap mode, an input-valid qualifier and a saturating match counter. It sits on a serial input line and reports each occurrence of the pattern to downstream control logic.

## Interface
- N, default 6: pattern length in bits, ≥ 2.
- PATTERN, default 6'b101011: pattern loaded at reset. The MSB is the first bit received.
- CNT_W, default 8: width of the match counter, ≥ 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- r  input  1  reset, synchronous, active-high.
- in  input  1  serial data bit.
- in_valid  input  1  `in` is sampled only when this is 1.
- overlap  input  1  mode select.
  - 1: matches may share bits.
  - 0: after a match, the next match needs N fresh bits.
- load  input  1  load a new pattern from `load_pattern`.
- load_pattern  input  N  new pattern, MSB first.
- out  output  1  one-cycle match pulse.
- match_count  output  CNT_W  number of matches since reset or load; saturates.
- pattern_q  output  N  currently active pattern.

## Operation
- Internal state:
  - `hist[N-1:0]`: shift history; newest bit in the LSB.
  - `fill`: count of valid bits accepted since the last clear, saturating at N.
  - `pat[N-1:0]`: active pattern.
- Priority on each rising edge: r > load > in_valid > idle.
- **r = 1:**
  - pat ← PATTERN; hist ← 0; fill ← 0.
  - out ← 0; match_count ← 0.
- **load = 1 (r = 0):**
  - pat ← load_pattern; hist ← 0; fill ← 0.
  - out ← 0; match_count ← 0.
  - `in` is ignored that cycle, even if in_valid = 1.
- **in_valid = 1:**
  - hist_n = {hist[N-2:0], in}; fill_n = min(fill+1, N).
  - match = (fill_n == N) && (hist_n == pat).
  - hist ← hist_n; out ← match.
  - If match: match_count ← match_count+1, saturating at 2^CNT_W−1.
  - If match and overlap = 0: fill ← 0. Otherwise fill ← fill_n.
- **in_valid = 0:** hist, fill, pat and match_count hold; out ← 0.
- State view, equivalent to the N+1-state cycle-detector FSM:
  - fill = 0…N−1: partial-fill states.
  - fill = N: armed state; every valid bit can produce a match.
  - Non-overlap match returns to fill = 0.
- `overlap` is sampled on every valid bit. Changing it mid-stream affects only the clear decision for the current bit.
- pattern_q = pat, driven combinationally from the register.
- Arithmetic:
  - fill is ⌈log2(N+1)⌉ bits.
  - match_count never wraps; it holds at all-ones.

## Timing
- Reset values: out = 0, match_count = 0, pattern_q = PATTERN.
- Latency: out goes high in the cycle immediately after the edge that samples the final pattern bit, one clk of latency. It lasts exactly one cycle per match.
- match_count updates on the same edge as out rises.
- Consecutive valid cycles can produce consecutive out pulses, e.g. pattern all-ones in overlap mode.
- Gaps in in_valid do not break a partial match; bits need not be consecutive cycles.
- load followed by valid bits:
  - the first sampled bit is on the next edge with in_valid = 1 and load = 0;
  - the earliest match is N valid bits later.
- Reset mid-stream discards partial history, even if it coincides with the final pattern bit: no pulse, no count.
- load and in_valid in the same cycle: load wins, and the bit is dropped.

## Test plan
- **Default pattern 101011, overlap = 1:**
  - stimulus: in_valid = 1 with bits 1,0,1,0,1,1,0,1,0,1,1 on consecutive edges;
  - response: out pulses after bit 6 and after bit 11; match_count = 2.
- **Same stream, overlap = 0:**
  - response: out pulses only after bit 6; match_count = 1, because bits 7–11 supply only 5 fresh bits.
- **Gapped input:**
  - stimulus: the same 6-bit pattern with in_valid = 0 for 3 cycles between bits 3 and 4;
  - response: a single pulse after the 6th valid bit; out = 0 during the gaps.
- **Runtime load:**
  - stimulus: load = 1, load_pattern = 6'b111000 (with in_valid = 1, in = 1); then bits 1,1,1,0,0,0;
  - response: pattern_q = 111000; match_count reset to 0; the bit presented with load is ignored; one pulse after the 6th bit.
- **Counter saturation** (CNT_W = 2, pattern 6'b111111, overlap = 1):
  - stimulus: 12 ones;
  - response: 7 out pulses; match_count stops at 3.
- **Reset on final bit:**
  - stimulus: r = 1 on the edge carrying the 6th bit of 101011;
  - response: out = 0, match_count = 0, pattern_q = 101011, and no match after the next single bit.
